// File: rtl/bet_wl_scheduler.sv
// -----------------------------------------------------------------------------
// bet_wl_scheduler
//
// Static wear-leveling scheduler for the Block Erase Table (BET).
//
// The BET is an external single-port RAM holding one flag bit per physical
// block: a set flag means "this block has been erased since the table was
// last cleared" (hot), a clear flag means "cold". This block owns every
// access to that RAM and keeps two running totals:
//   e_cnt - total erase events (32-bit, saturating)
//   f_cnt - number of flagged blocks (0..BLOCKS)
// When e_cnt > T * f_cnt, erases are concentrating on a small hot set. The
// scheduler then walks the BET from a rotating pointer (f_index) looking for
// a cold block and offers it to garbage collection over a req/ack handshake
// so that its static data can be migrated onto a worn block.
//
// Parameters:
//   T       ratio threshold, 16-bit unsigned
//   BLOCKS  physical block count, power of two, at most 4096
//
// Ports:
//   clk_50       in   system clock
//   rst          in   synchronous active-low reset
//   erase_en     in   erase event valid
//   erase_addr   in   [11:0] erased block index
//   erase_ready  out  erase event may be accepted this cycle
//   bet_addr     out  [11:0] BET RAM address
//   bet_rd       out  BET read strobe; bet_rdata valid the following cycle
//   bet_rdata    in   BET flag read data
//   bet_wr_en    out  BET write strobe
//   bet_wdata    out  BET write data
//   gc_req       out  GC request, held until gc_ack
//   gc_addr      out  [11:0] cold block index, stable while gc_req=1
//   gc_ack       in   GC accepted the request
//   gc_issued    out  [15:0] completed GC handshakes (BET_WL_STATS_EN only)
//
// Build option:
//   BET_WL_STATS_EN - when defined, adds the gc_issued statistics output.
//                     It saturates at 0xFFFF and is cleared by rst only,
//                     never by a table clear.
// -----------------------------------------------------------------------------
module bet_wl_scheduler #(
  parameter logic [15:0] T      = 16'd100,
  parameter int unsigned BLOCKS = 4096
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        erase_en,
  input  logic [11:0] erase_addr,
  output logic        erase_ready,
  output logic [11:0] bet_addr,
  output logic        bet_rd,
  input  logic        bet_rdata,
  output logic        bet_wr_en,
  output logic        bet_wdata,
  output logic        gc_req,
  output logic [11:0] gc_addr,
  input  logic        gc_ack
`ifdef BET_WL_STATS_EN
  ,
  output logic [15:0] gc_issued
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [12:0] BLOCKS_W = 13'(BLOCKS);
  localparam logic [11:0] IDX_MASK = 12'(BLOCKS - 1);

  localparam logic [2:0] S_CLEAR    = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_E_RD     = 3'd2;
  localparam logic [2:0] S_E_CHK    = 3'd3;
  localparam logic [2:0] S_SCAN_RD  = 3'd4;
  localparam logic [2:0] S_SCAN_CHK = 3'd5;
  localparam logic [2:0] S_GC_REQ   = 3'd6;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]  state;
  logic [11:0] clr_idx;    // sweep pointer while clearing the table
  logic [31:0] e_cnt;      // erase events since the last clear
  logic [12:0] f_cnt;      // flagged blocks since the last clear
  logic [11:0] f_index;    // rotating cold-block search pointer
  logic [12:0] scan_cnt;   // blocks examined in the current scan
  logic        suppress;   // holds off re-trigger until the next erase
  logic [11:0] lat_addr;   // block of the erase being processed

  // ---------------------------------------------------------------------------
  // Derived values
  // ---------------------------------------------------------------------------
  // T*f_cnt never exceeds 0xFFFF*4096, so a 32-bit product cannot overflow.
  logic [31:0] thresh;
  logic        trigger;
  logic [12:0] f_cnt_inc;
  logic [12:0] scan_cnt_inc;
  logic [11:0] f_index_next;

  assign thresh       = 32'(T) * 32'(f_cnt);
  assign trigger      = !suppress && (e_cnt > thresh);
  assign f_cnt_inc    = f_cnt + 13'd1;
  assign scan_cnt_inc = scan_cnt + 13'd1;
  assign f_index_next = (f_index + 12'd1) & IDX_MASK;

  // ---------------------------------------------------------------------------
  // RAM port and handshake outputs, decoded from state
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so that no path leaves
  // it unassigned; otherwise synthesis would infer a latch to hold old values.
  always_comb begin
    erase_ready = 1'b0;
    bet_addr    = '0;
    bet_rd      = 1'b0;
    bet_wr_en   = 1'b0;
    bet_wdata   = 1'b0;
    gc_req      = 1'b0;
    case (state)
      S_CLEAR: begin
        bet_wr_en = 1'b1;
        bet_addr  = clr_idx;
      end
      S_IDLE: begin
        erase_ready = 1'b1;
      end
      S_E_RD: begin
        bet_rd   = 1'b1;
        bet_addr = lat_addr;
      end
      S_E_CHK: begin
        // Set the flag only for a block that was cold; a hot block needs no
        // write and leaves the port free.
        bet_addr = lat_addr;
        if (!bet_rdata) begin
          bet_wr_en = 1'b1;
          bet_wdata = 1'b1;
        end
      end
      S_SCAN_RD: begin
        // An arriving erase takes the RAM port this cycle; the scan read is
        // dropped and the scan is re-evaluated from IDLE afterwards.
        erase_ready = 1'b1;
        if (!erase_en) begin
          bet_rd   = 1'b1;
          bet_addr = f_index;
        end
      end
      S_GC_REQ: begin
        gc_req = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; the reset branch is sampled on the clock edge
  // only, so rst is treated as an ordinary synchronous input.
  always_ff @(posedge clk_50) begin
    if (!rst) begin
      // NOTE: the BET contents are not reset here; the RAM is zeroed by the
      // CLEAR sweep that reset leads into, one address per cycle.
      state     <= S_CLEAR;
      clr_idx   <= '0;
      e_cnt     <= '0;
      f_cnt     <= '0;
      f_index   <= '0;
      scan_cnt  <= '0;
      suppress  <= 1'b0;
      lat_addr  <= '0;
      gc_addr   <= '0;
`ifdef BET_WL_STATS_EN
      gc_issued <= '0;
`endif
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_idx == IDX_MASK) begin
            // Last address written: start a fresh accounting epoch.
            state    <= S_IDLE;
            clr_idx  <= '0;
            e_cnt    <= '0;
            f_cnt    <= '0;
            f_index  <= '0;
            suppress <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 12'd1;
          end
        end

        S_IDLE: begin
          // Erases always take priority over starting a scan.
          if (erase_en) begin
            lat_addr <= erase_addr & IDX_MASK;
            state    <= S_E_RD;
          end else if (trigger) begin
            scan_cnt <= '0;
            state    <= S_SCAN_RD;
          end
        end

        S_E_RD: begin
          if (e_cnt != '1) begin
            e_cnt <= e_cnt + 32'd1;
          end
          suppress <= 1'b0;
          state    <= S_E_CHK;
        end

        S_E_CHK: begin
          if (!bet_rdata) begin
            f_cnt <= f_cnt_inc;
          end
          // Every block flagged: the ratio carries no information any more,
          // so wipe the table and restart the epoch.
          if (!bet_rdata && (f_cnt_inc == BLOCKS_W)) begin
            clr_idx <= '0;
            state   <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end

        S_SCAN_RD: begin
          if (erase_en) begin
            lat_addr <= erase_addr & IDX_MASK;
            state    <= S_E_RD;
          end else begin
            state <= S_SCAN_CHK;
          end
        end

        S_SCAN_CHK: begin
          if (!bet_rdata) begin
            gc_addr <= f_index;
            state   <= S_GC_REQ;
          end else begin
            f_index  <= f_index_next;
            scan_cnt <= scan_cnt_inc;
            // A full lap without a cold block means the RAM disagrees with
            // f_cnt; give up rather than loop forever inside the scan.
            if (scan_cnt_inc == BLOCKS_W) begin
              state <= S_IDLE;
            end else begin
              state <= S_SCAN_RD;
            end
          end
        end

        S_GC_REQ: begin
          if (gc_ack) begin
            f_index  <= f_index_next;
            suppress <= 1'b1;
            state    <= S_IDLE;
`ifdef BET_WL_STATS_EN
            if (gc_issued != 16'hFFFF) begin
              gc_issued <= gc_issued + 16'd1;
            end
`endif
          end
        end

        default: begin
          state <= S_CLEAR;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interface properties
  // ---------------------------------------------------------------------------
  a_single_port: assert property (@(posedge clk_50) !(bet_rd && bet_wr_en));

  a_gc_hold: assert property (@(posedge clk_50) disable iff (!rst)
    (gc_req && !gc_ack) |=> (gc_req && $stable(gc_addr)));

endmodule

// File: tb/tb_bet_wl_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bet_wl_scheduler
//
// Bench for bet_wl_scheduler with BLOCKS=16 and T=2. It owns a 16-bit BET
// RAM model answering the DUT's read/write strobes, drives directed erase and
// GC-ack sequences, and runs one compare process that keeps a transaction
// level model of the wear-leveling rules (flag set, erase/flag totals,
// pointer, suppress) and checks the DUT against it on every clock.
// -----------------------------------------------------------------------------
module tb_bet_wl_scheduler;

  localparam int          NB = 16;
  localparam logic [15:0] TH = 16'd2;

  logic        clk_50     = 1'b0;
  logic        rst        = 1'b0;
  logic        erase_en   = 1'b0;
  logic [11:0] erase_addr = '0;
  logic        gc_ack     = 1'b0;
  logic        bet_rdata  = 1'b0;
  logic        erase_ready;
  logic [11:0] bet_addr;
  logic        bet_rd;
  logic        bet_wr_en;
  logic        bet_wdata;
  logic        gc_req;
  logic [11:0] gc_addr;
`ifdef BET_WL_STATS_EN
  logic [15:0] gc_issued;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #10 clk_50 = ~clk_50;

  bet_wl_scheduler #(.T(TH), .BLOCKS(NB)) dut (
    .clk_50      (clk_50),
    .rst         (rst),
    .erase_en    (erase_en),
    .erase_addr  (erase_addr),
    .erase_ready (erase_ready),
    .bet_addr    (bet_addr),
    .bet_rd      (bet_rd),
    .bet_rdata   (bet_rdata),
    .bet_wr_en   (bet_wr_en),
    .bet_wdata   (bet_wdata),
    .gc_req      (gc_req),
    .gc_addr     (gc_addr),
    .gc_ack      (gc_ack)
`ifdef BET_WL_STATS_EN
    ,
    .gc_issued   (gc_issued)
`endif
  );

  // BET RAM: one registered read port, one write port, plus a bench-only
  // preload used to plant hot flags without going through erases.
  logic [NB-1:0] ram_bits = '0;
  logic          pre_go   = 1'b0;
  logic [NB-1:0] pre_mask = '0;

  always @(posedge clk_50) begin
    if (bet_wr_en) ram_bits[bet_addr[3:0]] <= bet_wdata;
    if (pre_go)    ram_bits <= ram_bits | pre_mask;
    if (bet_rd)    bet_rdata <= ram_bits[bet_addr[3:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the wear-leveling rules
  // ---------------------------------------------------------------------------
  logic [NB-1:0] m_flag;
  logic [31:0]   m_e;
  int            m_f;
  int            m_fidx;
  logic          m_sup;
  int            m_clr;
  int            m_last;
  int            m_gci;

  task automatic model_reset();
    m_flag = '0; m_e = '0; m_f = 0; m_fidx = 0; m_sup = 1'b0;
    m_clr = 0; m_last = 0; m_gci = 0;
  endtask

  function automatic int cold_idx();
    for (int k = 0; k < NB; k++)
      if (!m_flag[(m_fidx + k) % NB]) return (m_fidx + k) % NB;
    return -1;
  endfunction

  function automatic bit m_trig();
    return !m_sup && (m_e > 32'(TH) * 32'(m_f));
  endfunction

  task automatic monitor();
    logic        prev_req  = 1'b0;
    logic [11:0] prev_addr = '0;
    forever begin
      @(negedge clk_50);
      if (!rst) begin
        model_reset();
        prev_req = 1'b0;
      end else begin
        check("one_port", {31'b0, bet_rd & bet_wr_en}, 32'd0);
        if (bet_wr_en && !bet_wdata) begin
          check("clr_addr", bet_addr, m_clr);
          check("clr_not_ready", erase_ready, 1'b0);
          m_clr = (m_clr + 1) % NB;
        end
        if (bet_wr_en && bet_wdata) check("flag_wr_addr", bet_addr, m_last);
        if (gc_req) begin
          check("gc_trig_model", m_trig(), 1'b1);
          check("gc_addr_model", gc_addr, cold_idx());
          check("gc_not_ready", erase_ready, 1'b0);
          if (prev_req) check("gc_addr_stable", gc_addr, prev_addr);
        end
`ifdef BET_WL_STATS_EN
        check("gc_issued_model", gc_issued, m_gci);
`endif
        prev_req  = gc_req;
        prev_addr = gc_addr;
        // Advance the model by the transactions completing at the next edge.
        if (pre_go) m_flag = m_flag | pre_mask;
        if (erase_en && erase_ready) begin
          m_last = int'(erase_addr) % NB;
          if (m_e != '1) m_e = m_e + 32'd1;
          m_sup = 1'b0;
          if (!m_flag[m_last]) begin
            m_flag[m_last] = 1'b1;
            m_f++;
          end
          if (m_f == NB) begin
            m_flag = '0; m_e = '0; m_f = 0; m_fidx = 0; m_sup = 1'b0;
          end
        end
        if (gc_req && gc_ack) begin
          m_fidx = (cold_idx() + 1) % NB;
          m_sup  = 1'b1;
          if (m_gci != 16'hFFFF) m_gci++;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers
  // ---------------------------------------------------------------------------
  // Returns at 2ns after the edge that accepted the erase (the E_RD cycle).
  task automatic do_erase(input int a);
    int waited;
    @(posedge clk_50); #2;
    erase_en = 1'b1; erase_addr = 12'(a);
    @(negedge clk_50);
    waited = 0;
    while (!erase_ready && waited < 200) begin
      @(negedge clk_50);
      waited++;
    end
    check("erase_accepted", {31'b0, waited < 200}, 32'd1);
    @(posedge clk_50); #2;
    erase_en = 1'b0;
  endtask

  // Counts negedges until gc_req is seen, bounded.
  task automatic wait_gc(output int n);
    n = 0;
    do begin
      @(negedge clk_50);
      n++;
    end while (!gc_req && n < 200);
    check("gc_req_seen", gc_req, 1'b1);
  endtask

  task automatic do_ack();
    @(posedge clk_50); #2; gc_ack = 1'b1;
    @(posedge clk_50); #2; gc_ack = 1'b0;
  endtask

  // Counts cycles with a BET read over a window; used to confirm no scan.
  task automatic count_reads(input int cycles, output int reads);
    reads = 0;
    repeat (cycles) begin
      @(negedge clk_50);
      if (bet_rd) reads++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_50); #2; rst = 1'b0;
    @(posedge clk_50);
    @(negedge clk_50);
    check("rst_gc_req", gc_req, 1'b0);
    check("rst_gc_addr", gc_addr, 12'd0);
    check("rst_ready", erase_ready, 1'b0);
    check("rst_bet_rd", bet_rd, 1'b0);
    check("rst_clr0", {bet_wr_en, bet_wdata, bet_addr}, {1'b1, 1'b0, 12'd0});
`ifdef BET_WL_STATS_EN
    check("rst_gc_issued", gc_issued, 16'd0);
`endif
    @(posedge clk_50); #2; rst = 1'b1;
    for (int c = 1; c <= NB + 1; c++) begin
      @(negedge clk_50);
      if (c <= NB) begin
        check("clr_sweep", {bet_wr_en, bet_wdata, bet_addr}, {1'b1, 1'b0, 12'(c - 1)});
        check("clr_ready_low", erase_ready, 1'b0);
      end else begin
        check("first_ready", erase_ready, 1'b1);
        check("idle_gc_low", gc_req, 1'b0);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int reads;
    int wr0;
    model_reset();
    fork
      monitor();
    join_none

    // Reset and first clear sweep.
    repeat (2) @(posedge clk_50);
    do_reset();

    // One erase of block 3: e=1, f=1, 1 > 2 false, no scan.
    do_erase(3);
    repeat (2) @(negedge clk_50);
    count_reads(10, reads);
    check("no_trigger_1", reads, 0);
    // An ack outside GC_REQ must be ignored.
    @(posedge clk_50); #2; gc_ack = 1'b1;
    @(posedge clk_50); #2; gc_ack = 1'b0;
    // Two more erases of block 3: e=3 > 2*1, scan from 0, block 0 is cold.
    do_erase(3);
    do_erase(3);
    wait_gc(n);
    check("gc_latency_direct", n, 6);
    check("gc_addr_first", gc_addr, 12'd0);
    do_ack();
    @(negedge clk_50);
    check("gc_req_drop_after_ack", gc_req, 1'b0);
    count_reads(10, reads);
    check("suppress_holds", reads, 0);

    // Fresh table, flags 0..4 preloaded, trigger via three erases of 10.
    do_reset();
    @(posedge clk_50); #2; pre_mask = 16'h001F; pre_go = 1'b1;
    @(posedge clk_50); #2; pre_go = 1'b0;
    do_erase(10);
    do_erase(10);
    do_erase(10);
    wait_gc(n);
    // n counts from the E_RD cycle; trigger IDLE is the 3rd cycle after accept.
    check("skip5_trig_to_gc", n - 3, 13);
    check("gc_addr_skip5", gc_addr, 12'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50);
      check("gc_hold_req", gc_req, 1'b1);
      check("gc_hold_addr", gc_addr, 12'd5);
    end
    do_ack();

    // f_index=6. Erase 11 (e=4,f=2), then erase 11 again to trigger, and
    // inject a third erase of 11 exactly in the SCAN_RD cycle.
    do_erase(11);
    repeat (3) @(negedge clk_50);
    @(posedge clk_50); #2; erase_en = 1'b1; erase_addr = 12'd11;
    @(negedge clk_50);
    check("pre_scan_accept", erase_ready, 1'b1);
    @(posedge clk_50); #2; erase_en = 1'b0;
    @(posedge clk_50);
    @(posedge clk_50);
    @(posedge clk_50); #2; erase_en = 1'b1; erase_addr = 12'd11;
    @(negedge clk_50);
    check("scan_rd_ready", erase_ready, 1'b1);
    check("scan_rd_yields", bet_rd, 1'b0);
    @(posedge clk_50); #2; erase_en = 1'b0;
    @(negedge clk_50);
    check("scan_erase_rd", {bet_rd, bet_addr}, {1'b1, 12'd11});
    wait_gc(n);
    check("rescan_latency", n, 5);
    check("gc_addr_rescan", gc_addr, 12'd6);

    // Reset while gc_req is high.
    check("gc_high_before_rst", gc_req, 1'b1);
    do_reset();

    // Erase all 16 blocks; the 16th sends the table back through a clear.
    for (int k = 0; k < NB - 1; k++) do_erase(k);
    do_erase(NB - 1);
    n = 0;
    wr0 = 0;
    do begin
      @(negedge clk_50);
      n++;
      if (bet_wr_en && !bet_wdata) wr0++;
    end while (!erase_ready && n < 200);
    check("full_clear_latency", n, 19);
    check("full_clear_writes", wr0, 16);

    // Counters and pointer are zero again: 3 erases of 5 trigger a scan
    // that finds block 0 cold. Ack is held high beforehand, so the request
    // lasts exactly one cycle.
    @(posedge clk_50); #2; gc_ack = 1'b1;
    do_erase(5);
    do_erase(5);
    do_erase(5);
    wait_gc(n);
    check("post_clear_latency", n, 6);
    check("post_clear_gc_addr", gc_addr, 12'd0);
    @(negedge clk_50);
    check("gc_pulse_single", gc_req, 1'b0);
    @(posedge clk_50); #2; gc_ack = 1'b0;
    count_reads(10, reads);
    check("suppress_after_pulse", reads, 0);
`ifdef BET_WL_STATS_EN
    check("gc_issued_final", gc_issued, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bet_wl_scheduler.md
# bet_wl_scheduler

Static wear-leveling scheduler for the Block Erase Table (BET). Owns the 1-bit-per-block BET flag RAM and counts total erases (e_cnt) and flagged blocks (f_cnt). When the erase-to-flag ratio exceeds T, it scans the BET for a cold (unflagged) block and hands it to garbage collection over a req/ack handshake. It sits between the flash erase path and the GC engine and sequences all BET RAM accesses.

## Interface
- T, 100: ratio threshold (16-bit unsigned).
- BLOCKS, 4096: physical block count; power of two, at most 4096.
- clk_50  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- erase_en  in  1  erase event valid.
- erase_addr  in  12  erased block index.
- erase_ready  out  1  erase event may be accepted this cycle.
- bet_addr  out  12  BET RAM address.
- bet_rd  out  1  BET read strobe; bet_rdata is valid the next cycle.
- bet_rdata  in  1  BET flag read data.
- bet_wr_en  out  1  BET write strobe.
- bet_wdata  out  1  BET write data.
- gc_req  out  1  GC request; held until gc_ack.
- gc_addr  out  12  cold block index; stable while gc_req=1.
- gc_ack  in  1  GC accepted the request.

## Operation
- Counters:
  - e_cnt is 32-bit and saturates at 0xFFFFFFFF.
  - f_cnt is 13-bit, range 0..BLOCKS.
  - f_index is 12-bit and wraps modulo BLOCKS.
  - scan_cnt is 13-bit.
  - suppress is a 1-bit flag.
- Trigger: e_cnt > T*f_cnt, unsigned, computed at 32 bits; suppress must be 0. With f_cnt=0, any e_cnt>0 triggers.
- States: CLEAR, IDLE, E_RD, E_CHK, SCAN_RD, SCAN_CHK, GC_REQ.
- CLEAR:
  - Each cycle writes bet_wdata=0 at bet_addr=clr_idx.
  - After BLOCKS cycles, zeroes e_cnt, f_cnt, f_index and suppress, then goes to IDLE.
  - erase_ready=0 throughout.
- IDLE, checked in priority order:
  - If erase_en: accept, latch erase_addr, go to E_RD.
  - Else if trigger: scan_cnt=0, go to SCAN_RD.
- E_RD: bet_rd=1 at the latched address; e_cnt+1; suppress cleared.
- E_CHK:
  - If bet_rdata=0: write 1, f_cnt+1.
  - If the new f_cnt==BLOCKS: go to CLEAR. Otherwise go to IDLE.
- SCAN_RD:
  - If erase_en: the erase is accepted and handled first (E_RD path). The scan is abandoned and re-evaluated from IDLE; f_index is kept.
  - Else: bet_rd=1 at f_index.
- SCAN_CHK:
  - If rdata=0: gc_addr=f_index, go to GC_REQ.
  - Else: f_index+1, scan_cnt+1. Go to IDLE if scan_cnt reaches BLOCKS (inconsistent RAM guard), otherwise back to SCAN_RD.
- GC_REQ:
  - gc_req=1 until gc_ack is sampled high.
  - Then f_index+1, suppress=1, go to IDLE.
  - suppress blocks re-triggering until the next accepted erase.
- erase_ready=1 only in IDLE and SCAN_RD.
- The BET RAM has a single port. At most one of bet_rd or bet_wr_en is high per cycle.

## Timing
- Reset (rst=0 at a clk_50 edge), in the following cycle:
  - State is CLEAR with clr_idx=0.
  - gc_req=0, gc_addr=0, erase_ready=0, bet_rd=0.
  - All counters are 0.
- The first erase_ready=1 occurs BLOCKS+1 cycles after rst is released.
- Reset mid-operation (including GC_REQ) behaves the same: gc_req drops immediately and the BET is re-cleared.
- Erase event costs 3 cycles: accept, E_RD, E_CHK. Back-to-back erases are accepted every 3 cycles.
- Scan costs 2 cycles per block examined.
- Trigger to gc_req: at least 3 cycles (IDLE, SCAN_RD, SCAN_CHK), plus 2 per flagged block skipped.
- An ack present in the first GC_REQ cycle is honoured, so gc_req is a single-cycle pulse.
- gc_ack is ignored outside GC_REQ.
- Erase and trigger in the same IDLE cycle: the erase wins.

## Configuration
- BET_WL_STATS_EN:
  - When defined, adds output gc_issued [15:0]. It counts completed GC handshakes, saturates at 0xFFFF, and is cleared by rst only (not by CLEAR completion).
  - When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset, BLOCKS=16: 16 bet_wr_en writes of 0 at addresses 0..15 → erase_ready rises in cycle 17; gc_req=0.
- BLOCKS=16, T=2; erase block 3 once → e_cnt=1, f_cnt=1, no trigger. Erase block 3 twice more → e_cnt=3 > 2, scan from f_index=0 → gc_req with gc_addr=0. Ack → suppress=1, f_index=1.
- Preload flags 0..4 = 1, then force the trigger → scan skips five blocks, gc_addr=5, gc_req 13 cycles after the trigger cycle; hold gc_ack low 10 cycles → gc_req and gc_addr stay stable.
- erase_en asserted during SCAN_RD → erase serviced, f_index unchanged, scan restarted from IDLE.
- Erase all 16 distinct blocks → 16th erase sends E_CHK to CLEAR, 16 clear writes, counters zero.
- rst asserted while gc_req=1 → gc_req=0 next cycle, full CLEAR sweep. With BET_WL_STATS_EN, gc_issued=0.
